// File: rtl/gf2m_reduce_32.sv
// Digit-serial reduction of a 63-bit carry-less product modulo a degree-32 irreducible f(x).
// DIGIT high-order coefficients are folded back into the lower bits each RUN cycle.
module gf2m_reduce_32 #(
  parameter int          M     = 32,
  parameter logic [31:0] POLY  = 32'h0040_0007,
  parameter int          DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*M-2:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_data,
  output logic             busy
);

  localparam int W  = 2 * M - 1;
  localparam int N  = (M - 1 + DIGIT - 1) / DIGIT;
  localparam int KW = 6;
  // Full f(x) including the implied x^M term, aligned so bit M is the leading coefficient.
  localparam logic [W-1:0] FPOLY = {{(M - 2){1'b0}}, 1'b1, POLY[M-1:0]};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    r_reg;
  logic [KW-1:0]   k_reg;
  logic [W-1:0]    chain_w [0:DIGIT];

  assign chain_w[0] = r_reg;

  // Each stage clears one leading coefficient and sees the result of the stage above it.
  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_digit
      logic [7:0] off_w;
      logic [5:0] pos_w;
      logic [4:0] sh_w;
      logic       hit_w;

      assign off_w = 8'(32'(k_reg) * DIGIT + gi);
      assign pos_w = 6'(W - 1 - 32'(off_w));
      assign sh_w  = 5'(M - 2 - 32'(off_w));
      assign hit_w = (32'(off_w) <= M - 2) && chain_w[gi][pos_w];
      assign chain_w[gi+1] = hit_w ? (chain_w[gi] ^ (FPOLY << sh_w)) : chain_w[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      k_reg     <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            r_reg     <= in_data;
            k_reg     <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          r_reg <= chain_w[DIGIT];
          k_reg <= k_reg + 1'b1;
          if (k_reg == KW'(N - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = r_reg[M-1:0];

endmodule
